// File: rtl/can_bus_model.sv
// can_bus_model: wired-AND CAN bus with per-node rx delay, stuck-dominant monitor and SOF counter; CAN_BUS_FAULT_INJ_EN adds rx fault injection
module can_bus_model #(
  parameter int NUM_NODES   = 10,
  parameter int DELAY_MAX   = 15,
  parameter int DOM_TIMEOUT = 1024,
  parameter int CNT_W       = 16,
  localparam int DW = $clog2(DELAY_MAX + 1),
  localparam int TW = $clog2(DOM_TIMEOUT + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_NODES-1:0]    tx,
  input  logic [NUM_NODES-1:0]    fr,
  input  logic [NUM_NODES-1:0]    node_en,
  input  logic [NUM_NODES*DW-1:0] node_dly,
  output logic [NUM_NODES-1:0]    rx,
  output logic                    bus_lvl,
  output logic                    stuck_dom,
  output logic                    stuck_err,
  output logic [CNT_W-1:0]        sof_cnt,
  input  logic                    clr
`ifdef CAN_BUS_FAULT_INJ_EN
  ,
  input  logic                         inj_valid,
  output logic                         inj_ready,
  input  logic [$clog2(NUM_NODES)-1:0] inj_node,
  input  logic [7:0]                   inj_len
`endif
);

  logic [NUM_NODES-1:0] tx_c;
  logic                 bus_d;
  logic [DELAY_MAX:1]   dl;
  logic [DELAY_MAX:0]   taps;
  logic [TW-1:0]        dom_cnt;
  logic                 dom_set;
  logic [NUM_NODES-1:0] rx_d;
  logic [DW-1:0]        dly;

  assign taps      = {dl, bus_lvl};
  assign stuck_dom = dom_cnt == TW'(DOM_TIMEOUT);
  assign dom_set   = !bus_lvl && dom_cnt == TW'(DOM_TIMEOUT - 1);

  // wired-AND resolution; anything but a clean 0 on tx reads as recessive
  always_comb begin
    tx_c = '1;
    for (int i = 0; i < NUM_NODES; i++)
      case (tx[i])
        1'b0:    tx_c[i] = 1'b0;
        default: tx_c[i] = 1'b1;
      endcase
    bus_d = (&(tx_c | ~node_en)) | (|(fr & node_en));
  end

  // stage 0, delay line, dominant run length, sticky error and SOF counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus_lvl   <= 1'b1;
      dl        <= '1;
      dom_cnt   <= '0;
      stuck_err <= 1'b0;
      sof_cnt   <= '0;
    end else begin
      bus_lvl   <= bus_d;
      dl        <= taps[DELAY_MAX-1:0];
      dom_cnt   <= bus_lvl ? '0 : stuck_dom ? dom_cnt : dom_cnt + 1'b1;
      stuck_err <= dom_set | (stuck_err & ~clr);
      sof_cnt   <= clr ? '0 : (dl[1] & ~bus_lvl & ~(&sof_cnt)) ? sof_cnt + 1'b1 : sof_cnt;
    end

  // per-node tap select, delays beyond the line clamp to its last stage
  always_comb begin
    rx_d = '1;
    dly  = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      dly     = node_dly[i*DW +: DW];
      rx_d[i] = taps[dly > DW'(DELAY_MAX) ? DW'(DELAY_MAX) : dly];
    end
  end

`ifdef CAN_BUS_FAULT_INJ_EN
  logic [7:0]                   inj_cnt;
  logic [$clog2(NUM_NODES)-1:0] inj_sel;

  assign inj_ready = inj_cnt == '0;
  assign rx        = rx_d ^ ({NUM_NODES{~inj_ready}} & (NUM_NODES'(1) << inj_sel));

  // injection window: loads on an accepted in-range request, then counts down to idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inj_cnt <= '0;
      inj_sel <= '0;
    end else if (inj_valid && inj_ready) begin
      inj_cnt <= int'(inj_node) < NUM_NODES ? inj_len : '0;
      inj_sel <= inj_node;
    end else if (!inj_ready) begin
      inj_cnt <= inj_cnt - 1'b1;
    end
`else
  assign rx = rx_d;
`endif

endmodule

// File: tb/tb_can_bus_model.sv
// tb_can_bus_model: scoreboard bench for can_bus_model (default build, no fault injection)
module tb_can_bus_model;
  localparam int N    = 10;
  localparam int DMAX = 12;
  localparam int TO   = 1024;
  localparam int CW   = 8;
  localparam int DW   = $clog2(DMAX + 1);
  localparam logic [N-1:0] ALL = '1;

  logic          clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic [N-1:0]  tx = '1, fr = '0, node_en = '1;
  logic [N*DW-1:0] node_dly = '0;
  logic [N-1:0]  rx;
  logic          bus_lvl, stuck_dom, stuck_err;
  logic [CW-1:0] sof_cnt;

  can_bus_model #(.NUM_NODES(N), .DELAY_MAX(DMAX), .DOM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .tx(tx), .fr(fr), .node_en(node_en), .node_dly(node_dly),
    .rx(rx), .bus_lvl(bus_lvl), .stuck_dom(stuck_dom), .stuck_err(stuck_err),
    .sof_cnt(sof_cnt), .clr(clr)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int sig; logic [31:0] exp; } exp_t;
  exp_t sb[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   mdom, msof, dly[N];
  logic mb_prev, mb_cur, merr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic string sname(input int s);
    return s < N ? $sformatf("rx%0d", s) : s == N ? "bus_lvl" : s == N + 1 ? "sof_cnt" :
           s == N + 2 ? "stuck_dom" : "stuck_err";
  endfunction

  function automatic logic [31:0] probe(input int s);
    return s < N ? 32'(rx[s]) : s == N ? 32'(bus_lvl) : s == N + 1 ? 32'(sof_cnt) :
           s == N + 2 ? 32'(stuck_dom) : 32'(stuck_err);
  endfunction

  function automatic logic model(input logic [N-1:0] t, f, e);
    logic dom = 1'b0, frc = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (e[i] && !t[i]) dom = 1'b1;
      if (e[i] && f[i]) frc = 1'b1;
    end
    return frc || !dom;
  endfunction

  function automatic logic [N-1:0] lo(input int i);
    return ~(N'(1) << i);
  endfunction

  task automatic push(input int due, input int sig, input logic [31:0] exp);
    exp_t e;
    e.due = due; e.sig = sig; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    sb.delete();
    mdom = 0; msof = 0; merr = 1'b0; mb_prev = 1'b1; mb_cur = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due <= cyc) begin
        check(sname(sb[i].sig), probe(sb[i].sig), sb[i].exp);
        sb.delete(i);
      end
  endtask

  task automatic cycle(input logic [N-1:0] t, f, e, input logic c);
    logic b, set;
    tx = t; fr = f; node_en = e; clr = c;
    b    = model(t, f, e);
    set  = (mdom == TO - 1) && !mb_cur;
    mdom = mb_cur ? 0 : (mdom < TO ? mdom + 1 : TO);
    merr = set ? 1'b1 : c ? 1'b0 : merr;
    msof = c ? 0 : (mb_prev && !mb_cur && msof < (1 << CW) - 1) ? msof + 1 : msof;
    mb_prev = mb_cur;
    mb_cur  = b;
    push(cyc + 1, N, 32'(b));
    push(cyc + 1, N + 1, 32'(msof));
    push(cyc + 1, N + 2, 32'(mdom == TO));
    push(cyc + 1, N + 3, 32'(merr));
    for (int i = 0; i < N; i++) push(cyc + 1 + (dly[i] > DMAX ? DMAX : dly[i]), i, 32'(b));
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(ALL, '0, ALL, 1'b0);
  endtask

  task automatic set_dly(input int i, input int d);
    dly[i] = d;
    node_dly[i*DW +: DW] = DW'(d);
  endtask

  initial begin
    for (int i = 0; i < N; i++) dly[i] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx", 32'(rx), 32'(ALL));
    check("reset_bus", 32'(bus_lvl), 32'd1);
    check("reset_sof", 32'(sof_cnt), 32'd0);
    check("reset_stuck_dom", 32'(stuck_dom), 32'd0);
    check("reset_stuck_err", 32'(stuck_err), 32'd0);
    rst_n = 1'b1;
    idle(3);
    cycle(lo(0), '0, ALL, 1'b0);
    check("arb_rx_all_low", 32'(rx), 32'd0);
    idle(4);
    check("arb_sof_one", 32'(sof_cnt), 32'd1);
    repeat (3) cycle(lo(3), ~lo(5), ALL, 1'b0);
    check("force_rx_high", 32'(rx), 32'(ALL));
    repeat (3) cycle(lo(3), ~lo(5), lo(5), 1'b0);
    check("en5_off_rx_low", 32'(rx), 32'd0);
    repeat (3) cycle(lo(3), ~lo(5), lo(5) & lo(3), 1'b0);
    check("en3_off_rx_high", 32'(rx), 32'(ALL));
    idle(15);
    set_dly(2, 7);
    set_dly(6, 15);
    idle(15);
    cycle(lo(1), '0, ALL, 1'b0);
    idle(20);
    set_dly(2, 0);
    set_dly(6, 0);
    idle(15);
    repeat (1030) cycle(lo(0), '0, ALL, 1'b0);
    check("stuck_dom_held", 32'(stuck_dom), 32'd1);
    idle(5);
    check("stuck_err_sticky", 32'(stuck_err), 32'd1);
    cycle(ALL, '0, ALL, 1'b1);
    idle(3);
    check("stuck_err_cleared", 32'(stuck_err), 32'd0);
    repeat (260) begin
      cycle(lo(4), '0, ALL, 1'b0);
      idle(1);
    end
    idle(2);
    check("sof_saturated", 32'(sof_cnt), 32'(CW'('1)));
    cycle(ALL, '0, ALL, 1'b1);
    idle(2);
    check("sof_cleared", 32'(sof_cnt), 32'd0);
    repeat (3) cycle(lo(7), '0, ALL, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midframe_rst_rx", 32'(rx), 32'(ALL));
    check("midframe_rst_bus", 32'(bus_lvl), 32'd1);
    model_reset();
    tx = '1; clr = 1'b0;
    step();
    rst_n = 1'b1;
    idle(20);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
